branch_resolver: RTL and testbench

Pipelined branch-resolution unit for the single-cycle/pipelined CPU datapath. It accepts a conditional-branch request with two register operands, the branch PC, an immediate offset and the fetch-stage prediction. It evaluates equality and ordering between the operands, computes the taken flag, branch target and next PC, and reports misprediction. It sits between register read and the PC-update/flush logic. It is the consumer of the comparator's eq/less semantics, with a valid/ready handshake on both ends.

---
 rtl/br_pkg.sv | 28 ++
 rtl/br_cmp.sv | 32 +++
 rtl/branch_resolver.sv | 106 ++++++++++
 tb/tb_branch_resolver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared opcodes, PC increment and S1 payload for the branch resolver.
// BR_UNSIGNED_EN adds the unsigned-compare flag to the payload.
package br_pkg;

    localparam int W = 32;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam logic [W-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [2:0]   op;
        logic         pred;
        logic         eq;
        logic         lt_s;
`ifdef BR_UNSIGNED_EN
        logic         lt_u;
`endif
        logic [W-1:0] target;
        logic [W-1:0] pc4;
    } s1_t;

endpackage

// File: rtl/br_cmp.sv
// Operand comparator: equality, signed and (with BR_UNSIGNED_EN) unsigned less-than.
// Purely combinational, no handshake.
module br_cmp
    import br_pkg::*;
(
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         eq_o,
`ifdef BR_UNSIGNED_EN
    output logic         lt_u_o,
`endif
    output logic         lt_s_o
);

`ifdef BR_UNSIGNED_EN
    logic [W:0] diff_x;
    assign diff_x = {1'b0, a_i} - {1'b0, b_i};
    assign lt_u_o = diff_x[W];
    logic [W-1:0] diff;
    assign diff = diff_x[W-1:0];
`else
    logic [W-1:0] diff;
    assign diff = a_i - b_i;
`endif

    // Signed overflow: operands differ in sign and result sign differs from a.
    logic ovf;
    assign ovf    = (a_i[W-1] != b_i[W-1]) && (diff[W-1] != a_i[W-1]);
    assign lt_s_o = diff[W-1] ^ ovf;
    assign eq_o   = (a_i == b_i);

endmodule

// File: rtl/branch_resolver.sv
// Two-stage branch resolver: compare + adders in S1, taken/next-PC/mispredict in S2.
// Latency 2 edges; valid/ready on both sides, in_ready combinational from out_ready. BR_UNSIGNED_EN enables bltu/bgeu.
module branch_resolver
    import br_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [W-1:0] in_pc,
    input  logic [W-1:0] in_imm,
    input  logic         in_pred_taken,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_taken,
    output logic [W-1:0] out_target,
    output logic [W-1:0] out_next_pc,
    output logic         out_mispredict,
    output logic         out_illegal
);

    s1_t          s1_d, s1_q;
    logic         s1_vld_q, s2_vld_q;
    logic         taken_d, taken_q, ill_d, ill_q, misp_d, misp_q;
    logic [W-1:0] target_q, next_pc_d, next_pc_q;
    logic         s2_open, s1_adv;

    br_cmp u_cmp (
        .a_i    (in_a),
        .b_i    (in_b),
        .eq_o   (s1_d.eq),
`ifdef BR_UNSIGNED_EN
        .lt_u_o (s1_d.lt_u),
`endif
        .lt_s_o (s1_d.lt_s)
    );

    assign s1_d.op     = in_op;
    assign s1_d.pred   = in_pred_taken;
    assign s1_d.target = in_pc + in_imm;
    assign s1_d.pc4    = in_pc + PC_INC;

    assign s2_open  = !s2_vld_q || out_ready;
    assign s1_adv   = s1_vld_q && s2_open;
    assign in_ready = !s1_vld_q || s1_adv;

    always_comb begin
        taken_d = 1'b0;
        ill_d   = 1'b0;
        case (s1_q.op)
            BR_BEQ:  taken_d = s1_q.eq;
            BR_BNE:  taken_d = !s1_q.eq;
            BR_BLT:  taken_d = s1_q.lt_s;
            BR_BGE:  taken_d = !s1_q.lt_s;
`ifdef BR_UNSIGNED_EN
            BR_BLTU: taken_d = s1_q.lt_u;
            BR_BGEU: taken_d = !s1_q.lt_u;
`endif
            default: ill_d = 1'b1;
        endcase
        next_pc_d = taken_d ? s1_q.target : s1_q.pc4;
        misp_d    = !ill_d && (taken_d != s1_q.pred);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q  <= 1'b0;
            s1_q      <= '0;
            s2_vld_q  <= 1'b0;
            taken_q   <= 1'b0;
            target_q  <= '0;
            next_pc_q <= '0;
            misp_q    <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_vld_q <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_q <= s1_d;
            end
            // S2 payload only changes when a new result moves in, so stalled outputs stay put.
            if (s2_open) begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    taken_q   <= taken_d;
                    target_q  <= s1_q.target;
                    next_pc_q <= next_pc_d;
                    misp_q    <= misp_d;
                    ill_q     <= ill_d;
                end
            end
        end
    end

    assign out_valid      = s2_vld_q;
    assign out_taken      = taken_q;
    assign out_target     = target_q;
    assign out_next_pc    = next_pc_q;
    assign out_mispredict = misp_q;
    assign out_illegal    = ill_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver; expected results come from an independent model.
module tb_branch_resolver;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic [31:0] next_pc;
        logic        misp;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'b000;
    logic [31:0] in_a = '0, in_b = '0, in_pc = '0, in_imm = '0;
    logic        in_pred_taken = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [31:0] out_target, out_next_pc;
    logic        out_mispredict, out_illegal;

    logic        man_rdy = 1'b1;
    logic        pat_rdy = 1'b1;
    logic        pat_en  = 1'b0;
    assign out_ready = pat_en ? pat_rdy : man_rdy;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    branch_resolver dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_pc          (in_pc),
        .in_imm         (in_imm),
        .in_pred_taken  (in_pred_taken),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_taken      (out_taken),
        .out_target     (out_target),
        .out_next_pc    (out_next_pc),
        .out_mispredict (out_mispredict),
        .out_illegal    (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        exp_t e;
        logic t, il;
        t  = 1'b0;
        il = 1'b0;
        case (op)
            3'b000: t = (a == b);
            3'b001: t = (a != b);
            3'b100: t = ($signed(a) <  $signed(b));
            3'b101: t = ($signed(a) >= $signed(b));
`ifdef BR_UNSIGNED_EN
            3'b110: t = (a <  b);
            3'b111: t = (a >= b);
`endif
            default: il = 1'b1;
        endcase
        e.taken   = t;
        e.ill     = il;
        e.target  = pc + imm;
        e.next_pc = t ? pc + imm : pc + 32'd4;
        e.misp    = il ? 1'b0 : (t != pred);
        return e;
    endfunction

    // Handshakes are decided at the next posedge; inputs only change just after posedges.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    chk("taken",   32'(out_taken),      32'(sb[0].taken));
                    chk("target",  out_target,           sb[0].target);
                    chk("next_pc", out_next_pc,          sb[0].next_pc);
                    chk("misp",    32'(out_mispredict),  32'(sb[0].misp));
                    chk("illegal", 32'(out_illegal),     32'(sb[0].ill));
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (in_valid && in_ready)
                sb.push_back(model(in_op, in_a, in_b, in_pc, in_imm, in_pred_taken));
        end
    end

    initial begin
        int pc_n;
        pc_n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (pat_en) begin
                pat_rdy = ((pc_n % 3) == 0);
                pc_n++;
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        logic ok;
        in_valid = 1'b1;
        in_op = op; in_a = a; in_b = b; in_pc = pc; in_imm = imm; in_pred_taken = pred;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) return;
        end
        chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        man_rdy  = 1'b1;
        pat_en   = 1'b0;
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
        @(posedge clk);
        #1;
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid),      32'd0);
        chk("rst_in_ready",  32'(in_ready),       32'd1);
        chk("rst_taken",     32'(out_taken),      32'd0);
        chk("rst_target",    out_target,          32'd0);
        chk("rst_next_pc",   out_next_pc,         32'd0);
        chk("rst_misp",      32'(out_mispredict), 32'd0);
        chk("rst_illegal",   32'(out_illegal),    32'd0);
        @(posedge clk);
        #1;

        // Single beq: result visible after the second edge, not the first.
        send(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_edge1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_edge2_valid", 32'(out_valid), 32'd1);
        chk("beq_target_abs",  out_target,     32'h120);
        @(posedge clk);
        #1;

        send(3'b100, 32'h8000_0000, 32'd1, 32'h200, 32'h40, 1'b0);
        send(3'b101, 32'h8000_0000, 32'd1, 32'h204, 32'h40, 1'b1);
        send(3'b110, 32'h8000_0000, 32'd1, 32'h208, 32'h40, 1'b1);
        send(3'b111, 32'h8000_0000, 32'd1, 32'h20C, 32'h40, 1'b0);
        send(3'b000, 32'd7, 32'd7, 32'hFFFF_FFFC, 32'd8, 1'b1);
        send(3'b010, 32'd1, 32'd2, 32'h300, 32'h10, 1'b1);
        send(3'b011, 32'd1, 32'd1, 32'h304, 32'hFFFF_FFF0, 1'b0);
        send(3'b001, 32'd3, 32'd4, 32'h308, 32'hFFFF_FFF0, 1'b1);
        drain();

        // Back-to-back stream under a 1,0,0 ready pattern.
        pat_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, b;
            logic [2:0]  ops [8];
            ops = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
            a = $urandom;
            b = (i % 3 == 0) ? a : $urandom;
            send(ops[i], a, b, $urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        drain();

        // Reset with two requests in flight and the output stalled.
        man_rdy = 1'b0;
        send(3'b000, 32'd1, 32'd1, 32'h400, 32'h4, 1'b0);
        send(3'b001, 32'd1, 32'd2, 32'h404, 32'h4, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        man_rdy = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (6) @(negedge clk);
        chk("post_rst_idle", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
